csa_accumulator: RTL and testbench

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

---
 rtl/csa_accumulator.sv | 96 +++++++++
 tb/tb_csa_accumulator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/csa_accumulator.sv
// Carry-save batch accumulator: operands are compressed 3:2 into S/C registers,
// resolved with a single carry-propagate add at the end of each batch.
//
// state   | meaning
// --------+----------------------------------------------------------
// ACC     | accepting operands, compressing into S/C
// RESOLVE | one cycle: register S+C and beat count, clear S/C/counter
// HOLD    | result presented on out_*, waiting for out_ready
module csa_accumulator #(
  parameter int WIDTH       = 16,
  parameter int ACC_WIDTH   = 24,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_data,
  output logic [COUNT_WIDTH-1:0] out_count
);

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ACC_WIDTH-1:0]   s_reg, c_reg;
  logic [ACC_WIDTH-1:0]   d_ext, sum_bits, maj_bits;
  logic [COUNT_WIDTH-1:0] cnt;
  logic                   beat;
  logic                   cnt_full;

  assign d_ext    = ACC_WIDTH'(in_data);
  assign sum_bits = s_reg ^ c_reg ^ d_ext;
  assign maj_bits = (s_reg & c_reg) | (s_reg & d_ext) | (c_reg & d_ext);
  assign cnt_full = (cnt == {COUNT_WIDTH{1'b1}});
  assign beat     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = RESOLVE;
      end
      RESOLVE: state_nxt = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  // The top majority bit is dropped by the shift, which keeps the sum mod 2^ACC_WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg <= '0;
      c_reg <= '0;
      cnt   <= '0;
    end else if (state == RESOLVE) begin
      s_reg <= '0;
      c_reg <= '0;
      cnt   <= '0;
    end else if (beat) begin
      s_reg <= sum_bits;
      c_reg <= maj_bits << 1;
      if (!cnt_full) cnt <= cnt + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_count <= '0;
    end else if (state == RESOLVE) begin
      out_data  <= s_reg + c_reg;
      out_count <= cnt;
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed and randomized checks of csa_accumulator, including a 16-bit
// accumulator instance for the wrap-around case.
module tb_csa_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [23:0] out_data;
  logic [7:0]  out_count;

  logic        v16 = 1'b0, l16 = 1'b0, or16 = 1'b0;
  logic [15:0] d16 = '0;
  logic        r16, ov16;
  logic [15:0] od16;
  logic [7:0]  oc16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  csa_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  csa_accumulator #(.WIDTH(16), .ACC_WIDTH(16), .COUNT_WIDTH(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16),
    .in_data(d16), .in_last(l16), .out_valid(ov16),
    .out_ready(or16), .out_data(od16), .out_count(oc16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat; returns 1 ns after the edge that accepted it.
  task automatic send_beat(input logic [15:0] d, input logic last, input bit gaps);
    bit acc = 0;
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 2)) step();
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!acc && n < 50) begin
      acc = in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic get_result(input string tag, input logic [23:0] ed, input logic [7:0] ec,
                            input bit stall);
    bit done = 0;
    int n = 0;
    while (!done && n < 200) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        chk({tag, "_data"}, 32'(out_data), 32'(ed));
        chk({tag, "_count"}, 32'(out_count), 32'(ec));
        done = 1;
      end
      step();
      n++;
    end
    out_ready = 1'b0;
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [23:0] ref_sum;
    logic [23:0] held;
    int          nb;

    // reset values while rst is high
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("rst_ready", 32'(in_ready), 32'd1);

    // 1 + 2 + 3, check two-cycle latency and single-cycle out_valid
    out_ready = 1'b1;
    send_beat(16'h0001, 1'b0, 1'b0);
    send_beat(16'h0002, 1'b0, 1'b0);
    send_beat(16'h0003, 1'b1, 1'b0);
    chk("lat_resolve_valid", 32'(out_valid), 32'd0);
    chk("lat_resolve_ready", 32'(in_ready), 32'd0);
    step();
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data", 32'(out_data), 32'd6);
    chk("basic_count", 32'(out_count), 32'd3);
    step();
    chk("basic_valid_1cyc", 32'(out_valid), 32'd0);
    chk("basic_ready_back", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // 256 x 0xFFFF: sum 0xFFFF00, count saturates at 255
    for (int i = 0; i < 256; i++) send_beat(16'hFFFF, (i == 255), 1'b0);
    get_result("sat", 24'hFFFF00, 8'd255, 1'b0);

    // single-operand batch
    send_beat(16'h1234, 1'b1, 1'b0);
    get_result("single", 24'h001234, 8'd1, 1'b0);

    // ACC_WIDTH = 16 wrap-around: 0xFFFF + 0x0002 = 0x0001
    v16 = 1'b1; d16 = 16'hFFFF; l16 = 1'b0;
    step();
    d16 = 16'h0002; l16 = 1'b1;
    step();
    v16 = 1'b0; l16 = 1'b0;
    step();
    chk("wrap_valid", 32'(ov16), 32'd1);
    chk("wrap_data", 32'(od16), 32'h0001);
    chk("wrap_count", 32'(oc16), 32'd2);
    or16 = 1'b1;
    step();
    or16 = 1'b0;
    chk("wrap_valid_drop", 32'(ov16), 32'd0);

    // backpressure in HOLD with in_valid held high
    send_beat(16'h0100, 1'b0, 1'b0);
    send_beat(16'h0023, 1'b1, 1'b0);
    step();
    held = out_data;
    chk("bp_data", 32'(held), 32'h000123);
    in_valid = 1'b1; in_data = 16'h7777; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready_low", 32'(in_ready), 32'd0);
      chk("bp_valid_high", 32'(out_valid), 32'd1);
      chk("bp_data_stable", 32'(out_data), 32'(held));
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    get_result("bp_release", 24'h000123, 8'd2, 1'b0);
    send_beat(16'h000A, 1'b0, 1'b0);
    send_beat(16'h0014, 1'b1, 1'b0);
    get_result("bp_next", 24'h00001E, 8'd2, 1'b0);

    // reset mid-batch discards the partial sum
    send_beat(16'h0064, 1'b0, 1'b0);
    send_beat(16'h00C8, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    step();
    rst = 1'b0;
    send_beat(16'h0005, 1'b0, 1'b0);
    send_beat(16'h0007, 1'b1, 1'b0);
    get_result("midrst", 24'h00000C, 8'd2, 1'b0);

    // reset during HOLD drops the pending result
    send_beat(16'h0009, 1'b1, 1'b0);
    step();
    chk("hold_rst_pre", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #2;
    chk("hold_rst_valid", 32'(out_valid), 32'd0);
    chk("hold_rst_data", 32'(out_data), 32'd0);
    step();
    rst = 1'b0;
    chk("hold_rst_ready", 32'(in_ready), 32'd1);

    // randomized batches with valid/ready stalls
    for (int b = 0; b < 12; b++) begin
      nb = $urandom_range(1, 40);
      ref_sum = '0;
      for (int i = 0; i < nb; i++) begin
        logic [15:0] d;
        d = 16'($urandom);
        ref_sum = ref_sum + 24'(d);
        send_beat(d, (i == nb - 1), 1'b1);
      end
      get_result("rand", ref_sum, 8'(nb), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
